// File: rtl/cregister_reader.sv
// ----------------------------------------------------------------------------
// cregister_reader
//
// Purpose:
//   Samples a watched register value into a 2-entry FIFO and presents the
//   oldest sample to a valid/ready consumer. A sample is taken on an explicit
//   read request. When change_only=1, a sample is also taken whenever the
//   watched value differs from its value in the previous cycle. If the FIFO
//   is full and not draining, the new sample is dropped and a sticky overrun
//   flag is raised.
//
// Parameters:
//   datawidth     - width of the sampled data path in bits
//   change_only   - 1 enables automatic sampling on a change of reg_data
//
// Ports:
//   clk           in   single clock; all state updates on its rising edge
//   reset         in   synchronous, active-high reset
//   reg_data      in   watched register value
//   read_req      in   sample reg_data in this cycle
//   output_data   out  head sample (last popped value, or 0 after reset,
//                      when the FIFO is empty)
//   output_valid  out  output_data holds an unconsumed sample
//   output_ready  in   consumer accepts the head sample
//   count         out  number of buffered samples (0..2)
//   overrun       out  sticky flag, set when a sample is dropped
//   clear_overrun in   clears overrun (a same-cycle drop wins)
// ----------------------------------------------------------------------------
module cregister_reader #(
    parameter int unsigned datawidth   = 8,
    parameter bit          change_only = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [datawidth-1:0] reg_data,
    input  logic                 read_req,
    output logic [datawidth-1:0] output_data,
    output logic                 output_valid,
    input  logic                 output_ready,
    output logic [1:0]           count,
    output logic                 overrun,
    input  logic                 clear_overrun
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e               r_state;
    // Shift arrangement: r_head drives output_data directly, r_tail holds the
    // second (younger) sample when two are buffered.
    logic [datawidth-1:0] r_head;
    logic [datawidth-1:0] r_tail;
    logic                 r_valid;
    logic [1:0]           r_count;
    logic                 r_overrun;
    logic [datawidth-1:0] r_last;
    logic                 r_primed;

    logic w_change;
    logic w_push;
    logic w_pop;
    logic w_drop;

    // Change trigger is suppressed in the first cycle after reset, when r_last
    // still holds its reset value rather than a real previous sample.
    assign w_change = change_only && r_primed && (reg_data != r_last);
    // A request and a change in the same cycle collapse into a single push.
    assign w_push   = read_req || w_change;
    assign w_pop    = r_valid && output_ready;
    assign w_drop   = (r_state == StTwo) && w_push && !w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StEmpty;
            r_head    <= '0;
            r_tail    <= '0;
            r_valid   <= 1'b0;
            r_count   <= 2'd0;
            r_overrun <= 1'b0;
            r_last    <= '0;
            r_primed  <= 1'b0;
        end else begin
            r_last   <= reg_data;
            r_primed <= 1'b1;

            // Set wins over clear.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clear_overrun) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                StEmpty: begin
                    // output_valid is 0 here, so no pop can occur.
                    if (w_push) begin
                        r_head  <= reg_data;
                        r_state <= StOne;
                        r_valid <= 1'b1;
                        r_count <= 2'd1;
                    end
                end

                StOne: begin
                    if (w_push && !w_pop) begin
                        r_tail  <= reg_data;
                        r_state <= StTwo;
                        r_count <= 2'd2;
                    end else if (!w_push && w_pop) begin
                        // r_head keeps the popped value for display while empty.
                        r_state <= StEmpty;
                        r_valid <= 1'b0;
                        r_count <= 2'd0;
                    end else if (w_push && w_pop) begin
                        r_head <= reg_data;
                    end
                end

                StTwo: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (w_push) begin
                            r_tail <= reg_data;
                        end else begin
                            r_state <= StOne;
                            r_count <= 2'd1;
                        end
                    end
                    // Push without pop is a drop: contents unchanged.
                end

                default: begin
                    r_state <= StEmpty;
                    r_valid <= 1'b0;
                    r_count <= 2'd0;
                end
            endcase
        end
    end

    assign output_data  = r_head;
    assign output_valid = r_valid;
    assign count        = r_count;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_cregister_reader.sv
// ----------------------------------------------------------------------------
// tb_cregister_reader
//
// Directed bench for cregister_reader. Instance u_dut_req uses
// change_only=0 for request-driven behaviour; u_dut_chg uses change_only=1
// for change-triggered sampling. Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_cregister_reader;

    logic       clk;

    logic       a_reset;
    logic [7:0] a_reg_data;
    logic       a_read_req;
    logic [7:0] a_output_data;
    logic       a_output_valid;
    logic       a_output_ready;
    logic [1:0] a_count;
    logic       a_overrun;
    logic       a_clear_overrun;

    logic       b_reset;
    logic [7:0] b_reg_data;
    logic       b_read_req;
    logic [7:0] b_output_data;
    logic       b_output_valid;
    logic       b_output_ready;
    logic [1:0] b_count;
    logic       b_overrun;
    logic       b_clear_overrun;

    int n_tests = 0;
    int n_fail  = 0;

    cregister_reader #(
        .datawidth  (8),
        .change_only(1'b0)
    ) u_dut_req (
        .clk          (clk),
        .reset        (a_reset),
        .reg_data     (a_reg_data),
        .read_req     (a_read_req),
        .output_data  (a_output_data),
        .output_valid (a_output_valid),
        .output_ready (a_output_ready),
        .count        (a_count),
        .overrun      (a_overrun),
        .clear_overrun(a_clear_overrun)
    );

    cregister_reader #(
        .datawidth  (8),
        .change_only(1'b1)
    ) u_dut_chg (
        .clk          (clk),
        .reset        (b_reset),
        .reg_data     (b_reg_data),
        .read_req     (b_read_req),
        .output_data  (b_output_data),
        .output_valid (b_output_valid),
        .output_ready (b_output_ready),
        .count        (b_count),
        .overrun      (b_overrun),
        .clear_overrun(b_clear_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        a_reset = 1'b1; a_reg_data = 8'h00; a_read_req = 1'b0;
        a_output_ready = 1'b0; a_clear_overrun = 1'b0;
        b_reset = 1'b1; b_reg_data = 8'h00; b_read_req = 1'b0;
        b_output_ready = 1'b0; b_clear_overrun = 1'b0;

        // Reset state.
        tick();
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_valid", 32'(a_output_valid), 32'd0);
        chk("rst_data", 32'(a_output_data), 32'h00);
        chk("rst_overrun", 32'(a_overrun), 32'd0);
        a_reset = 1'b0;
        b_reset = 1'b0;

        // Single request.
        a_reg_data = 8'h5A; a_read_req = 1'b1;
        tick();
        a_read_req = 1'b0;
        chk("single_valid", 32'(a_output_valid), 32'd1);
        chk("single_data", 32'(a_output_data), 32'h5A);
        chk("single_count", 32'(a_count), 32'd1);
        tick();
        chk("hold_data", 32'(a_output_data), 32'h5A);
        chk("hold_count", 32'(a_count), 32'd1);
        a_output_ready = 1'b1;
        tick();
        a_output_ready = 1'b0;
        chk("single_pop_count", 32'(a_count), 32'd0);
        chk("single_pop_valid", 32'(a_output_valid), 32'd0);
        chk("empty_last_popped", 32'(a_output_data), 32'h5A);

        // Overflow: third sample dropped.
        a_read_req = 1'b1;
        a_reg_data = 8'h01; tick();
        a_reg_data = 8'h02; tick();
        a_reg_data = 8'h03; tick();
        a_read_req = 1'b0;
        chk("ovf_count", 32'(a_count), 32'd2);
        chk("ovf_overrun", 32'(a_overrun), 32'd1);
        chk("ovf_head", 32'(a_output_data), 32'h01);
        a_output_ready = 1'b1;
        tick();
        chk("ovf_pop1_data", 32'(a_output_data), 32'h02);
        chk("ovf_pop1_count", 32'(a_count), 32'd1);
        tick();
        a_output_ready = 1'b0;
        chk("ovf_pop2_count", 32'(a_count), 32'd0);
        chk("ovf_sticky", 32'(a_overrun), 32'd1);
        a_clear_overrun = 1'b1;
        tick();
        a_clear_overrun = 1'b0;
        chk("ovf_cleared", 32'(a_overrun), 32'd0);

        // Push and pop together while full.
        a_read_req = 1'b1;
        a_reg_data = 8'h11; tick();
        a_reg_data = 8'h22; tick();
        chk("full_count", 32'(a_count), 32'd2);
        chk("full_head", 32'(a_output_data), 32'h11);
        a_reg_data = 8'h33; a_output_ready = 1'b1;
        tick();
        a_read_req = 1'b0;
        chk("pp_count", 32'(a_count), 32'd2);
        chk("pp_head", 32'(a_output_data), 32'h22);
        chk("pp_overrun", 32'(a_overrun), 32'd0);
        tick();
        chk("pp_next", 32'(a_output_data), 32'h33);
        chk("pp_next_count", 32'(a_count), 32'd1);
        tick();
        a_output_ready = 1'b0;
        chk("pp_drained", 32'(a_count), 32'd0);

        // Drop coinciding with clear_overrun: set wins.
        a_read_req = 1'b1;
        a_reg_data = 8'h44; tick();
        a_reg_data = 8'h55; tick();
        a_reg_data = 8'h66; a_clear_overrun = 1'b1;
        tick();
        a_read_req = 1'b0; a_clear_overrun = 1'b0;
        chk("setwins_overrun", 32'(a_overrun), 32'd1);
        chk("setwins_head", 32'(a_output_data), 32'h44);
        tick();
        chk("stall_head", 32'(a_output_data), 32'h44);

        // Reset mid-operation with a request in the reset cycle.
        a_reset = 1'b1; a_read_req = 1'b1; a_reg_data = 8'h77;
        tick();
        a_reset = 1'b0; a_read_req = 1'b0;
        chk("midrst_count", 32'(a_count), 32'd0);
        chk("midrst_valid", 32'(a_output_valid), 32'd0);
        chk("midrst_data", 32'(a_output_data), 32'h00);
        chk("midrst_overrun", 32'(a_overrun), 32'd0);
        tick();
        chk("midrst_req_ignored", 32'(a_count), 32'd0);

        // Change mode: reg_data held at 0 after reset, then 0x07, 0x09.
        b_reset = 1'b1; b_reg_data = 8'h00;
        tick();
        b_reset = 1'b0;
        tick();
        chk("chg_idle", 32'(b_count), 32'd0);
        b_reg_data = 8'h07; tick();
        b_reg_data = 8'h09; tick();
        tick();
        chk("chg_count", 32'(b_count), 32'd2);
        chk("chg_head", 32'(b_output_data), 32'h07);
        b_output_ready = 1'b1;
        tick();
        chk("chg_second", 32'(b_output_data), 32'h09);
        tick();
        b_output_ready = 1'b0;
        chk("chg_drained", 32'(b_count), 32'd0);
        tick();
        chk("chg_no_spurious", 32'(b_count), 32'd0);

        // Request and change in the same cycle: one push.
        b_reg_data = 8'h20; b_read_req = 1'b1;
        tick();
        b_read_req = 1'b0;
        chk("sim_count", 32'(b_count), 32'd1);
        chk("sim_data", 32'(b_output_data), 32'h20);
        tick();
        chk("sim_count_hold", 32'(b_count), 32'd1);
        b_output_ready = 1'b1;
        tick();
        b_output_ready = 1'b0;

        // reg_data already 0x07 at reset release: no sample.
        b_reset = 1'b1; b_reg_data = 8'h07;
        tick();
        b_reset = 1'b0;
        tick();
        chk("prime_first", 32'(b_count), 32'd0);
        tick();
        chk("prime_second", 32'(b_count), 32'd0);
        chk("prime_valid", 32'(b_output_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
